// File: rtl/i2s_pkg.sv
// i2s_pkg: frame geometry, FSM state type and bit-counter helpers
// shared by the I2S transmitter and receiver.
package i2s_pkg;

    localparam int CHNL_W   = 24;
    localparam int FRM_BITS = 48;
    localparam int K_W      = 6;

    localparam logic [K_W-1:0] K_LAST  = 6'd47;
    localparam logic [K_W-1:0] K_WS_HI = 6'd23;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    // ws level driven after fall k: right channel is announced one bit early
    function automatic logic ws_after(input logic [K_W-1:0] k);
        return (k >= K_WS_HI) && (k < K_LAST);
    endfunction

    function automatic logic [K_W-1:0] k_next(input logic [K_W-1:0] k);
        return (k == K_LAST) ? '0 : k + 1'b1;
    endfunction

endpackage

// File: rtl/i2s_xmtr_if.sv
// i2s_xmtr_if: sample-pair write port (vld/rdy) of the I2S transmitter.
// The producer side is master, the transmitter is slave.
interface i2s_xmtr_if;
    import i2s_pkg::*;

    logic [CHNL_W-1:0] lft_chnnl;
    logic [CHNL_W-1:0] rght_chnnl;
    logic              vld;
    logic              rdy;

    modport master (
        output lft_chnnl,
        output rght_chnnl,
        output vld,
        input  rdy
    );

    modport slave (
        input  lft_chnnl,
        input  rght_chnnl,
        input  vld,
        output rdy
    );

endinterface

// File: rtl/i2s_sclk_gen.sv
// i2s_sclk_gen: I2S bit-clock divider with fall/rise strobes; strobes are
// high in the clk cycle whose rising edge flips I2S_sclk.
module i2s_sclk_gen #(
    parameter int SCLK_HALF = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    input  logic i_preset,
    output logic o_sclk,
    output logic o_fall,
    output logic o_rise
);

    localparam logic [7:0] HALF_M1 = 8'(SCLK_HALF - 1);

    logic [7:0] r_cnt;
    logic       r_sclk;
    logic       w_tick;

    assign w_tick = i_run && (r_cnt == HALF_M1);
    assign o_fall = w_tick && r_sclk;
    assign o_rise = w_tick && !r_sclk;
    assign o_sclk = r_sclk;

    // Preset leaves sclk high one clk so the next tick is a fall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (i_preset) begin
            r_cnt  <= HALF_M1;
            r_sclk <= 1'b1;
        end else if (!i_run) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (w_tick) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
        end else begin
            r_cnt  <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/i2s_xmtr.sv
// i2s_xmtr: 24-bit stereo I2S transmitter with one-pair holding buffer.
// Left MSB reaches I2S_data 2*SCLK_HALF+1 clk after en is sampled high.
module i2s_xmtr
    import i2s_pkg::*;
#(
    parameter int SCLK_HALF = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    i2s_xmtr_if.slave  smp,
    output logic       I2S_sclk,
    output logic       I2S_ws,
    output logic       I2S_data,
    output logic       undrrun
);

    state_t                r_state;
    state_t                w_nxt;
    logic                  w_preset;
    logic                  w_term;
    logic                  w_run;
    logic                  w_fall;
    logic                  w_rise;
    logic                  w_load;
    logic                  w_wr;
    logic [K_W-1:0]        r_k;
    logic [K_W-1:0]        w_idx;
    logic [FRM_BITS-1:0]   r_sh;
    logic [FRM_BITS-1:0]   r_hold;
    logic                  r_full;
    logic                  r_tail;
    logic                  r_ws;
    logic                  r_data;
    logic                  r_urun;

    i2s_sclk_gen #(
        .SCLK_HALF (SCLK_HALF)
    ) u_sclk (
        .clk      (clk),
        .rst      (rst),
        .i_run    (w_run),
        .i_preset (w_preset),
        .o_sclk   (I2S_sclk),
        .o_fall   (w_fall),
        .o_rise   (w_rise)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nxt;
    end

    // DRAIN ends on the tick after the rise that follows fall 47
    always_comb begin
        w_nxt    = r_state;
        w_preset = 1'b0;
        w_term   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (en) begin
                    w_nxt    = RUN;
                    w_preset = 1'b1;
                end
            end
            RUN: begin
                if (!en) w_nxt = DRAIN;
            end
            DRAIN: begin
                if (en) begin
                    w_nxt = RUN;
                end else if (w_fall && r_tail) begin
                    w_nxt  = IDLE;
                    w_term = 1'b1;
                end
            end
            default: w_nxt = IDLE;
        endcase
    end

    assign w_run  = (r_state != IDLE);
    assign w_load = w_fall && (r_k == '0) && !w_term;
    assign w_wr   = smp.vld && !r_full;
    assign w_idx  = K_LAST - r_k;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= '0;
            r_full <= 1'b0;
        end else begin
            if (w_wr) r_hold <= {smp.lft_chnnl, smp.rght_chnnl};
            if (w_wr)        r_full <= 1'b1;
            else if (w_load) r_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tail <= 1'b0;
        end else if (w_rise && (r_k == '0)) begin
            r_tail <= 1'b1;
        end else if (w_fall || !w_run) begin
            r_tail <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k    <= '0;
            r_sh   <= '0;
            r_ws   <= 1'b1;
            r_data <= 1'b0;
            r_urun <= 1'b0;
        end else begin
            r_urun <= 1'b0;
            if (w_preset) begin
                r_k    <= K_LAST;
                r_ws   <= 1'b1;
                r_data <= 1'b0;
            end else if (!w_run || w_term) begin
                r_ws   <= 1'b1;
                r_data <= 1'b0;
            end else if (w_fall) begin
                r_k  <= k_next(r_k);
                r_ws <= ws_after(r_k);
                if (w_load) begin
                    r_sh   <= r_full ? r_hold : '0;
                    r_data <= r_full & r_hold[FRM_BITS-1];
                    r_urun <= !r_full;
                end else begin
                    r_data <= r_sh[w_idx];
                end
            end
        end
    end

    assign smp.rdy  = ~r_full;
    assign I2S_ws   = r_ws;
    assign I2S_data = r_data;
    assign undrrun  = r_urun;

endmodule

// File: tb/tb_i2s_xmtr.sv
// tb_i2s_xmtr: scenario bench for i2s_xmtr with a behavioural I2S
// receiver feeding a received-pair queue checked against an expected queue.
module tb_i2s_xmtr;
    import i2s_pkg::*;

    localparam int H = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic I2S_sclk, I2S_ws, I2S_data, undrrun;

    i2s_xmtr_if smp();

    i2s_xmtr #(.SCLK_HALF(H)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .smp      (smp.slave),
        .I2S_sclk (I2S_sclk),
        .I2S_ws   (I2S_ws),
        .I2S_data (I2S_data),
        .undrrun  (undrrun)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    logic [47:0] expq[$];
    logic [47:0] rxq[$];

    int   cyc = 0;
    logic p_sclk, p_ws;
    bit   is_fall, is_rise, is_term;
    int   tk, f0_cnt, urun_cnt;
    logic data_or;
    logic [23:0] rsh, rleft;
    int   rn;
    logic rwsp;
    bit   rhave;

    task automatic clear_tb();
        expq.delete();
        rxq.delete();
        p_sclk = 1'b0; p_ws = 1'b1;
        tk = 47; f0_cnt = 0; urun_cnt = 0; data_or = 1'b0;
        rsh = '0; rleft = '0; rn = 0; rwsp = 1'b1; rhave = 0;
    endtask

    // one clk; observe at the falling clk edge, track sclk falls and receive
    task automatic step();
        @(negedge clk);
        cyc++;
        is_fall = p_sclk && !I2S_sclk;
        is_rise = !p_sclk && I2S_sclk;
        is_term = 0;
        if (is_fall) begin
            if (!p_ws && I2S_ws && tk == 47) is_term = 1;
            else if (p_ws && !I2S_ws)        tk = 47;
            else                             tk = (tk == 47) ? 0 : tk + 1;
            if (tk == 0 && !is_term) f0_cnt++;
        end
        if (is_rise) begin
            rsh = {rsh[22:0], I2S_data};
            if (I2S_ws != rwsp) begin
                if (rn + 1 == 24) begin
                    if (!rwsp) begin
                        rleft = rsh; rhave = 1;
                    end else if (rhave) begin
                        rxq.push_back({rleft, rsh}); rhave = 0;
                    end
                end
                rn = 0;
            end else begin
                rn++;
            end
            rwsp = I2S_ws;
        end
        if (undrrun) urun_cnt++;
        data_or = data_or | I2S_data;
        p_sclk = I2S_sclk;
        p_ws = I2S_ws;
    endtask

    task automatic do_reset();
        en = 1'b0; smp.vld = 1'b0; rst = 1'b1;
        step(); step();
        rst = 1'b0;
        clear_tb();
        step();
    endtask

    task automatic write_pair(input logic [23:0] l, input logic [23:0] r);
        bit ok;
        ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            if (smp.rdy) begin
                smp.vld = 1'b1; smp.lft_chnnl = l; smp.rght_chnnl = r;
                step();
                smp.vld = 1'b0;
                expq.push_back({l, r});
                ok = 1;
            end else begin
                step();
            end
        end
        if (!ok) begin
            n_chk++; $display("FAIL write_rdy: got timeout want rdy=1");
        end
    endtask

    task automatic wait_fall(input int k);
        bit hit;
        hit = 0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            step();
            hit = is_fall && !is_term && tk == k;
        end
        if (!hit) begin
            n_chk++; $display("FAIL wait_fall: got timeout want fall %0d", k);
        end
    endtask

    task automatic wait_rx(input int n);
        for (int i = 0; i < 5000 && rxq.size() < n; i++) step();
        if (rxq.size() < n) begin
            n_chk++;
            $display("FAIL wait_rx: got %0d pairs want %0d", rxq.size(), n);
        end
    endtask

    task automatic test_reset();
        step(); step();
        n_chk++; if (I2S_sclk !== 1'b0) $display("FAIL rst_sclk: got %b want 0", I2S_sclk); else n_pass++;
        n_chk++; if (I2S_ws !== 1'b1) $display("FAIL rst_ws: got %b want 1", I2S_ws); else n_pass++;
        n_chk++; if (I2S_data !== 1'b0) $display("FAIL rst_data: got %b want 0", I2S_data); else n_pass++;
        n_chk++; if (undrrun !== 1'b0) $display("FAIL rst_urun: got %b want 0", undrrun); else n_pass++;
        n_chk++; if (smp.rdy !== 1'b1) $display("FAIL rst_rdy: got %b want 1", smp.rdy); else n_pass++;
        rst = 1'b0;
        clear_tb();
        step();
    endtask

    task automatic test_pattern();
        int c0;
        logic [47:0] g, w;
        do_reset();
        write_pair(24'hA5A5A5, 24'h3C3C3C);
        n_chk++; if (smp.rdy !== 1'b0) $display("FAIL pat_full: got rdy %b want 0", smp.rdy); else n_pass++;
        en = 1'b1; c0 = cyc;
        wait_fall(0);
        en = 1'b0;
        n_chk++; if (cyc - c0 != 2*H+2) $display("FAIL pat_lat: got %0d want %0d", cyc - c0, 2*H+2); else n_pass++;
        n_chk++; if (I2S_data !== 1'b1 || I2S_ws !== 1'b0) $display("FAIL pat_msb: got d%b ws%b want d1 ws0", I2S_data, I2S_ws); else n_pass++;
        n_chk++; if (smp.rdy !== 1'b1) $display("FAIL pat_rdy: got %b want 1", smp.rdy); else n_pass++;
        wait_fall(23);
        n_chk++; if (I2S_data !== 1'b1 || I2S_ws !== 1'b1) $display("FAIL pat_f23: got d%b ws%b want d1 ws1", I2S_data, I2S_ws); else n_pass++;
        wait_fall(24);
        n_chk++; if (I2S_data !== 1'b0 || I2S_ws !== 1'b1) $display("FAIL pat_f24: got d%b ws%b want d0 ws1", I2S_data, I2S_ws); else n_pass++;
        wait_rx(1);
        g = (rxq.size() > 0) ? rxq.pop_front() : 'x;
        w = expq.pop_front();
        n_chk++; if (g !== w) $display("FAIL pat_pair: got %h want %h", g, w); else n_pass++;
        n_chk++; if (urun_cnt != 0) $display("FAIL pat_urun: got %0d want 0", urun_cnt); else n_pass++;
    endtask

    task automatic test_underrun();
        logic [47:0] g, w;
        bit rose;
        do_reset();
        repeat (3) expq.push_back('0);
        en = 1'b1;
        wait_rx(2);
        n_chk++; if (urun_cnt != 2) $display("FAIL ur_cnt2: got %0d want 2", urun_cnt); else n_pass++;
        n_chk++; if (data_or !== 1'b0) $display("FAIL ur_data0: got %b want 0", data_or); else n_pass++;
        wait_fall(10);
        write_pair(24'h000001, 24'h800000);
        wait_rx(4);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            g = (rxq.size() > 0) ? rxq.pop_front() : 'x;
            w = expq.pop_front();
            n_chk++; if (g !== w) $display("FAIL ur_pair%0d: got %h want %h", i, g, w); else n_pass++;
        end
        rose = 0;
        repeat (3*H) begin
            step();
            if (is_rise) rose = 1;
        end
        n_chk++; if (urun_cnt != 3) $display("FAIL ur_cnt3: got %0d want 3", urun_cnt); else n_pass++;
        n_chk++; if (rose || I2S_sclk !== 1'b0) $display("FAIL ur_idle: got rise%0d sclk%b want 0 0", rose, I2S_sclk); else n_pass++;
    endtask

    task automatic test_full();
        logic [47:0] g, w;
        logic prev_rdy, any_rdy;
        bit hit;
        do_reset();
        write_pair(24'h123456, 24'h654321);
        any_rdy = 1'b0;
        smp.vld = 1'b1; smp.lft_chnnl = 24'h111111; smp.rght_chnnl = 24'h222222;
        repeat (6) begin
            step();
            any_rdy = any_rdy | smp.rdy;
        end
        smp.vld = 1'b0;
        n_chk++; if (any_rdy !== 1'b0) $display("FAIL full_rdy: got %b want 0", any_rdy); else n_pass++;
        en = 1'b1;
        hit = 0; prev_rdy = 1'b1;
        for (int i = 0; i < 1000 && !hit; i++) begin
            prev_rdy = smp.rdy;
            step();
            hit = is_fall && !is_term && tk == 0;
        end
        en = 1'b0;
        n_chk++; if (!hit || prev_rdy !== 1'b0 || smp.rdy !== 1'b1) $display("FAIL full_clr: got hit%0d pre%b post%b want 1 0 1", hit, prev_rdy, smp.rdy); else n_pass++;
        wait_rx(1);
        g = (rxq.size() > 0) ? rxq.pop_front() : 'x;
        w = expq.pop_front();
        n_chk++; if (g !== w) $display("FAIL full_pair: got %h want %h", g, w); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [47:0] g, w;
        do_reset();
        write_pair(24'($urandom()), 24'($urandom()));
        en = 1'b1;
        for (int i = 1; i < 8; i++) write_pair(24'($urandom()), 24'($urandom()));
        for (int i = 0; i < 2000 && f0_cnt < 8; i++) step();
        en = 1'b0;
        wait_rx(8);
        for (int i = 0; i < 8; i++) begin
            g = (rxq.size() > 0) ? rxq.pop_front() : 'x;
            w = expq.pop_front();
            n_chk++; if (g !== w) $display("FAIL b2b_pair%0d: got %h want %h", i, g, w); else n_pass++;
        end
        n_chk++; if (urun_cnt != 0) $display("FAIL b2b_urun: got %0d want 0", urun_cnt); else n_pass++;
    endtask

    task automatic test_drain();
        logic [47:0] g, w;
        bit rose, term;
        int ca, cb;
        do_reset();
        write_pair(24'hC0FFEE, 24'h0BEEF1);
        en = 1'b1;
        wait_fall(10);
        en = 1'b0;
        wait_rx(1);
        g = (rxq.size() > 0) ? rxq.pop_front() : 'x;
        w = expq.pop_front();
        n_chk++; if (g !== w) $display("FAIL dr_pair: got %h want %h", g, w); else n_pass++;
        term = 0;
        for (int i = 0; i < 4*H && !term; i++) begin
            step();
            term = is_term;
        end
        n_chk++; if (!term) $display("FAIL dr_term: got none want sclk fall to idle"); else n_pass++;
        rose = 0;
        repeat (3*H) begin
            step();
            if (is_rise) rose = 1;
        end
        n_chk++; if (rose || I2S_sclk !== 1'b0 || I2S_ws !== 1'b1 || I2S_data !== 1'b0) $display("FAIL dr_idle: got r%0d s%b w%b d%b want 0 0 1 0", rose, I2S_sclk, I2S_ws, I2S_data); else n_pass++;
        write_pair(24'h5A5A5A, 24'hA00005);
        en = 1'b1;
        wait_fall(0); ca = cyc;
        write_pair(24'h7FFFFF, 24'h800001);
        wait_fall(10);
        en = 1'b0;
        wait_fall(30);
        en = 1'b1;
        wait_fall(0); cb = cyc;
        en = 1'b0;
        n_chk++; if (cb - ca != 96*H) $display("FAIL dr_gap: got %0d want %0d", cb - ca, 96*H); else n_pass++;
        wait_rx(2);
        for (int i = 0; i < 2; i++) begin
            g = (rxq.size() > 0) ? rxq.pop_front() : 'x;
            w = expq.pop_front();
            n_chk++; if (g !== w) $display("FAIL dr_re%0d: got %h want %h", i, g, w); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [47:0] g, w;
        int c0;
        do_reset();
        write_pair(24'h000000, 24'hFFFFFF);
        en = 1'b1;
        wait_fall(0);
        write_pair(24'h444444, 24'h555555);
        wait_fall(30);
        repeat (H+1) step();
        n_chk++; if (I2S_sclk !== 1'b1 || I2S_data !== 1'b1 || smp.rdy !== 1'b0) $display("FAIL rm_pre: got s%b d%b r%b want 1 1 0", I2S_sclk, I2S_data, smp.rdy); else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_chk++; if (I2S_sclk !== 1'b0 || I2S_ws !== 1'b1 || I2S_data !== 1'b0 || undrrun !== 1'b0) $display("FAIL rm_out: got s%b w%b d%b u%b want 0 1 0 0", I2S_sclk, I2S_ws, I2S_data, undrrun); else n_pass++;
        n_chk++; if (smp.rdy !== 1'b1) $display("FAIL rm_rdy: got %b want 1", smp.rdy); else n_pass++;
        en = 1'b0;
        step();
        rst = 1'b0;
        clear_tb();
        step();
        expq.push_back('0);
        en = 1'b1; c0 = cyc;
        wait_fall(0);
        en = 1'b0;
        n_chk++; if (cyc - c0 != 2*H+2) $display("FAIL rm_lat: got %0d want %0d", cyc - c0, 2*H+2); else n_pass++;
        n_chk++; if (urun_cnt != 1 || I2S_data !== 1'b0) $display("FAIL rm_urun: got u%0d d%b want 1 0", urun_cnt, I2S_data); else n_pass++;
        wait_rx(1);
        g = (rxq.size() > 0) ? rxq.pop_front() : 'x;
        w = expq.pop_front();
        n_chk++; if (g !== w) $display("FAIL rm_pair: got %h want %h", g, w); else n_pass++;
    endtask

    initial begin
        smp.vld = 1'b0;
        smp.lft_chnnl = '0;
        smp.rght_chnnl = '0;
        clear_tb();
        test_reset();
        test_pattern();
        test_underrun();
        test_full();
        test_back_to_back();
        test_drain();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
